// File: rtl/poly_unshift_seq.sv
// ---------------------------------------------------------------------------
// poly_unshift_seq
//
// Iterative GF(2^8) inverse polynomial shifter.
// Computes aft = bef * x^(-amount) mod the AES-style reduction polynomial.
// Each clock undoes one xtime step, so it can rewind an xtime chain, for
// example during key-schedule rewinding or self-check on the decrypt side.
//
// Parameters:
//   POLY   low byte of the reduction polynomial (bit 0 must be set)
//   AMT_W  width of amount; maximum shift is 2^AMT_W-1
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  block can accept a request
//   bef        in   8-bit operand
//   amount     in   number of x^-1 steps
//   out_valid  out  result held
//   out_ready  in   consumer takes result
//   aft        out  8-bit result (8'h00 whenever out_valid is low)
//   busy       out  high whenever the block is not idle
//
// Optional feature (macro POLY_UNSHIFT_SEQ_OVERLAP_EN):
//   When defined, a new request can be accepted on the same edge that the
//   held result is consumed, so back-to-back amount-0 requests complete one
//   per cycle. When undefined, requests are accepted only in IDLE.
// ---------------------------------------------------------------------------
module poly_unshift_seq #(
    parameter logic [7:0] POLY  = 8'h1b,
    parameter int         AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       bef,
    input  logic [AMT_W-1:0] amount,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       aft,
    output logic             busy
);

    // Inverse of the reduction step. The forward xtime shifts left and folds
    // in POLY when bit 7 falls out; going backwards, an odd value must have
    // had POLY folded in, so XOR it back out and restore the lost x^8 term
    // as bit 7 after the right shift.
    localparam logic [7:0] INV = {1'b1, POLY[7:1]};

    // Without bit 0 set in POLY the forward map is not invertible.
    generate
        if (POLY[0] != 1'b1) begin : g_bad_poly
            $error("poly_unshift_seq: POLY[0] must be 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_data;
    logic [7:0]       w_next_data;
    logic [AMT_W-1:0] r_cnt;
    logic [AMT_W-1:0] w_next_cnt;
    logic [7:0]       w_inv;

    assign w_inv = {1'b0, r_data[7:1]} ^ (r_data[0] ? INV : 8'h00);
    assign busy  = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_data  <= 8'h00;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_data  <= w_next_data;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_data  = r_data;
        w_next_cnt   = r_cnt;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        aft          = 8'h00;

        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_data  = bef;
                    w_next_cnt   = amount;
                    w_next_state = (amount == '0) ? S_DONE : S_BUSY;
                end
            end

            S_BUSY: begin
                w_next_data = w_inv;
                w_next_cnt  = r_cnt - AMT_W'(1);
                // BUSY is only entered with a nonzero count, so the final
                // step is the one taken while the count reads 1.
                if (r_cnt <= AMT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end

            S_DONE: begin
                out_valid = 1'b1;
                aft       = r_data;
`ifdef POLY_UNSHIFT_SEQ_OVERLAP_EN
                // Consume and accept may share one edge: the new request
                // goes straight into DONE or BUSY without visiting IDLE.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_next_data  = bef;
                        w_next_cnt   = amount;
                        w_next_state = (amount == '0) ? S_DONE : S_BUSY;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
`else
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
`endif
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_poly_unshift_seq.sv
// ---------------------------------------------------------------------------
// tb_poly_unshift_seq
//
// Directed testbench for poly_unshift_seq. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Expected values are either
// hand-computed constants or come from a forward xtime model.
// ---------------------------------------------------------------------------
module tb_poly_unshift_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] bef;
    logic [2:0] amount;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] aft;
    logic       busy;

    int checks;
    int failures;

    poly_unshift_seq #(
        .POLY  (8'h1b),
        .AMT_W (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bef       (bef),
        .amount    (amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aft       (aft),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward reference model: multiply by x modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] s;
        s = {b[6:0], 1'b0};
        return b[7] ? (s ^ 8'h1b) : s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, measures cycles from the acceptance edge until
    // out_valid, captures aft, then consumes the result. Operand inputs are
    // scrambled right after acceptance to show they are not re-sampled.
    task automatic do_request(input logic [7:0] b, input logic [2:0] a,
                              output int lat, output logic [7:0] res,
                              output bit ok);
        int w;
        ok       = 1'b1;
        lat      = 0;
        res      = 8'h00;
        w        = 0;
        bef      = b;
        amount   = a;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) ok = 1'b0;
        tick();
        in_valid = 1'b0;
        bef      = ~b;
        amount   = ~a;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        res       = aft;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bef       = 8'h00;
        amount    = 3'd0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || aft !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_hold: ov=%b ir=%b busy=%b aft=%h required ov=0 ir=1 busy=0 aft=00",
                     out_valid, in_ready, busy, aft);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || aft !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_release: ov=%b ir=%b busy=%b aft=%h required ov=0 ir=1 busy=0 aft=00",
                     out_valid, in_ready, busy, aft);
        end
    endtask

    task automatic test_basic();
        int         lat;
        logic [7:0] res;
        bit         ok;
        do_request(8'h01, 3'd1, lat, res, ok);
        checks++;
        if (ok !== 1'b1 || res !== 8'h8d) begin
            failures++;
            $display("[TB] FAIL basic_value: got %h ok=%b required 8d", res, ok);
        end
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("[TB] FAIL basic_latency: got %0d required 2", lat);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || aft !== 8'h00 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_idle_after: ov=%b ir=%b aft=%h busy=%b required 0 1 00 0",
                     out_valid, in_ready, aft, busy);
        end
    endtask

    task automatic test_chain();
        int         lat;
        logic [7:0] res;
        bit         ok;
        do_request(8'h01, 3'd7, lat, res, ok);
        checks++;
        if (ok !== 1'b1 || res !== 8'h83 || lat !== 8) begin
            failures++;
            $display("[TB] FAIL chain_01_7: got %h lat=%0d ok=%b required 83 lat=8", res, lat, ok);
        end
        do_request(8'h80, 3'd7, lat, res, ok);
        checks++;
        if (ok !== 1'b1 || res !== 8'h01 || lat !== 8) begin
            failures++;
            $display("[TB] FAIL chain_80_7: got %h lat=%0d ok=%b required 01 lat=8", res, lat, ok);
        end
        do_request(8'h8e, 3'd3, lat, res, ok);
        checks++;
        if (ok !== 1'b1 || res !== 8'h57 || lat !== 4) begin
            failures++;
            $display("[TB] FAIL roundtrip_8e_3: got %h lat=%0d ok=%b required 57 lat=4", res, lat, ok);
        end
    endtask

    task automatic test_random_roundtrip();
        int         lat;
        logic [7:0] res;
        logic [7:0] b;
        logic [7:0] back;
        bit         ok;
        for (int a = 0; a < 8; a++) begin
            b = 8'($urandom_range(0, 255));
            do_request(b, 3'(a), lat, res, ok);
            back = res;
            for (int k = 0; k < a; k++) back = xtime(back);
            checks++;
            if (ok !== 1'b1 || back !== b || lat !== a + 1) begin
                failures++;
                $display("[TB] FAIL random_rt amt=%0d: bef=%h aft=%h fwd=%h lat=%0d ok=%b required fwd=%h lat=%0d",
                         a, b, res, back, lat, ok, b, a + 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int bad;
        bad       = 0;
        out_ready = 1'b0;
        bef       = 8'hc3;
        amount    = 3'd0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        bef      = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || aft !== 8'hc3 || in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("[TB] FAIL backpressure_hold cycle %0d: ov=%b aft=%h ir=%b busy=%b required 1 c3 0 1",
                         i, out_valid, aft, in_ready, busy);
            end
            tick();
        end
        checks++;
        if (bad != 0) failures++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || aft !== 8'h00) begin
            failures++;
            $display("[TB] FAIL backpressure_release: ov=%b ir=%b busy=%b aft=%h required 0 1 0 00",
                     out_valid, in_ready, busy, aft);
        end
    endtask

    task automatic test_reset_mid_op();
        int         lat;
        logic [7:0] res;
        bit         ok;
        bit         seen;
        bef      = 8'h01;
        amount   = 3'd5;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || aft !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_mid_op: ov=%b ir=%b busy=%b aft=%h required 0 1 0 00",
                     out_valid, in_ready, busy, aft);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_discard: stray out_valid=%b required 0", seen);
        end
        do_request(8'h02, 3'd1, lat, res, ok);
        checks++;
        if (ok !== 1'b1 || res !== 8'h01 || lat !== 2) begin
            failures++;
            $display("[TB] FAIL reset_recover: got %h lat=%0d ok=%b required 01 lat=2", res, lat, ok);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vals[4];
        int         resCyc[4];
        logic [7:0] resVal[4];
        int         nres;
        int         idx;
        int         cyc;
        int         gap;
        bit         accept;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
`ifdef POLY_UNSHIFT_SEQ_OVERLAP_EN
        gap = 1;
`else
        gap = 2;
`endif
        nres      = 0;
        idx       = 0;
        cyc       = 0;
        out_ready = 1'b1;
        bef       = vals[0];
        amount    = 3'd0;
        in_valid  = 1'b1;
        while (nres < 4 && cyc < 30) begin
            if (out_valid) begin
                resCyc[nres] = cyc;
                resVal[nres] = aft;
                nres++;
            end
            accept = in_valid && in_ready;
            tick();
            cyc++;
            if (accept) begin
                idx++;
                if (idx < 4) bef = vals[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (nres !== 4) begin
            failures++;
            $display("[TB] FAIL b2b_count: got %0d results required 4", nres);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (resVal[i] !== vals[i]) begin
                    failures++;
                    $display("[TB] FAIL b2b_value %0d: got %h required %h", i, resVal[i], vals[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (resCyc[i] - resCyc[i-1] !== gap) begin
                    failures++;
                    $display("[TB] FAIL b2b_gap %0d: got %0d required %0d", i, resCyc[i] - resCyc[i-1], gap);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_chain();
        test_random_roundtrip();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
